// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and defaults for the RV32I fetch stage.
//   - fetch_state_t : fetch FSM states (RUN, HOLD, DROP)
//   - ifid_t        : IF/ID pipeline register contents
//   - DEFAULT_*     : reset PC and bubble instruction defaults
//   - align_target  : clears the low two bits of a redirect target
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,   // request outstanding at PCF every cycle
      HOLD = 2'd1,   // fetched word parked in buf while StallF is high
      DROP = 2'd2    // wait out a response that a redirect made stale
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   localparam int IFID_W = $bits(ifid_t);

   // No misalignment trap exists, so the target is simply forced word-aligned.
   function automatic logic [31:0] align_target(input logic [31:0] t);
      return t & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// -----------------------------------------------------------------------------
// flopenrc
//   Register with asynchronous active-low reset, synchronous clear and enable.
//   Reset and clear both load INIT; clear has priority over enable.
//   Ports:
//     clk_i   in  1      clock (rising edge)
//     rst_ni  in  1      asynchronous reset, active low
//     en_i    in  1      load d_i when high
//     clr_i   in  1      synchronous clear to INIT
//     d_i     in  WIDTH  next value
//     q_o     out WIDTH  registered value
// -----------------------------------------------------------------------------
module flopenrc #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    q_o <= INIT;
      else if (clr_i) q_o <= INIT;
      else if (en_i)  q_o <= d_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage plus IF/ID register of a 5-stage RV32I pipeline.
//   Owns PCF and a single-outstanding request to instruction memory.
//
//   Memory handshake: imem_req is a request valid, held with a stable
//   imem_addr until imem_rvalid is seen; imem_rvalid may arrive in the same
//   cycle as imem_req. No separate ready exists: a response completes the
//   request. imem_req is low in HOLD and while reset is asserted.
//
//   Ports:
//     clk, reset(active-low async)           clock / reset
//     StallF, StallD, FlushD                 hazard unit controls
//     PCSrcE, PCTargetE[31:0]                redirect from EX
//     imem_req, imem_addr[31:0]              request to instruction memory
//     imem_rvalid, imem_rdata[31:0]          response from instruction memory
//     InstrD, PCD, PCPlus4D, ValidD          IF/ID register outputs
//     FetchBusyF                             no instruction delivered this cycle
//     state_dbg_o                            current fetch FSM state
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         StallF,
   input  logic         StallD,
   input  logic         FlushD,
   input  logic         PCSrcE,
   input  logic [31:0]  PCTargetE,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic [31:0]  InstrD,
   output logic [31:0]  PCD,
   output logic [31:0]  PCPlus4D,
   output logic         ValidD,
   output logic         FetchBusyF,
   output fetch_state_t state_dbg_o
);

   localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

   fetch_state_t state_q, state_d;
   logic [31:0]  pcf_q, pcf_d;
   logic [31:0]  buf_q, buf_d;
   logic [31:0]  pend_q, pend_d;
   logic [31:0]  pcf_plus4;
   logic [31:0]  target;
   ifid_t        ifid_d, ifid_q;

   assign pcf_plus4 = pcf_q + 32'd4;   // wraps modulo 2^32
   assign target    = align_target(PCTargetE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pcf_q   <= RESET_PC;
         buf_q   <= 32'h0;
         pend_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         pcf_q   <= pcf_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
      end
   end

   // Next state. Default IF/ID input is a bubble; StallD/FlushD are applied
   // by the IF/ID register itself, so they do not appear here.
   always_comb begin
      state_d = state_q;
      pcf_d   = pcf_q;
      buf_d   = buf_q;
      pend_d  = pend_q;
      ifid_d  = BUBBLE;
      case (state_q)
         RUN: begin
            if (PCSrcE && !imem_rvalid) begin
               state_d = DROP;
               pend_d  = target;
            end else if (PCSrcE) begin
               pcf_d = target;                 // response arrived but is stale
            end else if (imem_rvalid && !StallF) begin
               pcf_d  = pcf_plus4;
               ifid_d = '{instr: imem_rdata, pc: pcf_q, pc_plus4: pcf_plus4, valid: 1'b1};
            end else if (imem_rvalid) begin
               state_d = HOLD;
               buf_d   = imem_rdata;
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               state_d = RUN;
               pcf_d   = target;
            end else if (!StallF) begin
               state_d = RUN;
               pcf_d   = pcf_plus4;
               ifid_d  = '{instr: buf_q, pc: pcf_q, pc_plus4: pcf_plus4, valid: 1'b1};
            end
         end
         DROP: begin
            // A redirect arriving while draining replaces the pending target.
            if (imem_rvalid) begin
               state_d = RUN;
               pcf_d   = PCSrcE ? target : pend_q;
            end else if (PCSrcE) begin
               pend_d = target;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   flopenrc #(
      .WIDTH (IFID_W),
      .INIT  (BUBBLE)
   ) u_ifid (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (!StallD),
      .clr_i  (FlushD),
      .d_i    (ifid_d),
      .q_o    (ifid_q)
   );

   assign imem_req    = reset && (state_q != HOLD);
   assign imem_addr   = pcf_q;
   assign FetchBusyF  = ((state_q == RUN) && !imem_rvalid) || (state_q == DROP);
   assign InstrD      = ifid_q.instr;
   assign PCD         = ifid_q.pc;
   assign PCPlus4D    = ifid_q.pc_plus4;
   assign ValidD      = ifid_q.valid;
   assign state_dbg_o = state_q;

endmodule
